// File: rtl/mips_trace_buffer_if.sv
// Signals between the mips core, the trace buffer and the log sink:
// per-cycle write events in, a 3-beat valid/ready record stream and status out.
interface mips_trace_buffer_if #(
  parameter int ADDR_W = 4
);
  logic [31:0]     pc_now;
  logic [31:0]     addr_now;
  logic [31:0]     data_now;
  logic            if_reg;
  logic            if_mem;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_word;
  logic            out_last;
  logic            cpu_stall;
  logic [ADDR_W:0] level;
  logic [15:0]     drop_cnt;

  modport slave (
    input  pc_now, addr_now, data_now, if_reg, if_mem, out_ready,
    output out_valid, out_word, out_last, cpu_stall, level, drop_cnt
  );

  modport master (
    output pc_now, addr_now, data_now, if_reg, if_mem, out_ready,
    input  out_valid, out_word, out_last, cpu_stall, level, drop_cnt
  );
endinterface

// File: rtl/mips_trace_buffer.sv
// Captures mips architectural write events into a record FIFO and drains each
// record as three words (type/PC, address, data) on a valid/ready stream.
module mips_trace_buffer #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  mips_trace_buffer_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_W0, S_W1, S_W2} state_t;

  typedef struct packed {
    logic [1:0]  kind;
    logic [29:0] pc_word;
    logic [31:0] addr;
    logic [31:0] data;
  } record_t;

  localparam logic [ADDR_W:0]   LVL_FULL  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   LVL_STALL = (ADDR_W + 1)'(DEPTH - 2);
  localparam logic [ADDR_W:0]   LVL_ONE   = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);

  state_t            r_state;
  state_t            w_state_next;
  record_t           r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_level;
  logic [ADDR_W:0]   w_level_next;
  logic [15:0]       r_drop_cnt;
  logic              w_evt;
  logic              w_push;
  logic              w_pop;
  record_t           w_rec;
  record_t           w_head;
  logic              w_unused_pc;

  assign w_evt  = bus.if_reg | bus.if_mem;
  assign w_pop  = (r_state == S_W2) && bus.out_ready;
  // A full FIFO still accepts a record when the head leaves on the same edge.
  assign w_push = w_evt && ((r_level != LVL_FULL) || w_pop);
  assign w_rec  = '{kind:    {bus.if_mem, bus.if_reg},
                    pc_word: bus.pc_now[31:2],
                    addr:    bus.addr_now,
                    data:    bus.data_now};
  assign w_head = r_mem[r_rd_ptr];
  assign w_unused_pc = ^bus.pc_now[1:0];

  always_comb begin
    w_level_next = r_level;
    case ({w_push, w_pop})
      2'b10:   w_level_next = r_level + LVL_ONE;
      2'b01:   w_level_next = r_level - LVL_ONE;
      default: w_level_next = r_level;
    endcase
  end

  // NOTE: all state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_drop_cnt <= '0;
    end else begin
      r_state <= w_state_next;
      r_level <= w_level_next;
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      if (w_evt && !w_push && (r_drop_cnt != 16'hFFFF))
        r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  // NOTE: record storage has no reset; pointers and level alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_rec;
  end

  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    w_state_next  = r_state;
    bus.out_valid = 1'b0;
    bus.out_word  = '0;
    bus.out_last  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_level != '0) w_state_next = S_W0;
      end
      S_W0: begin
        bus.out_valid = 1'b1;
        bus.out_word  = {w_head.kind, w_head.pc_word};
        if (bus.out_ready) w_state_next = S_W1;
      end
      S_W1: begin
        bus.out_valid = 1'b1;
        bus.out_word  = w_head.addr;
        if (bus.out_ready) w_state_next = S_W2;
      end
      S_W2: begin
        bus.out_valid = 1'b1;
        bus.out_word  = w_head.data;
        bus.out_last  = 1'b1;
        if (bus.out_ready) w_state_next = (w_level_next != '0) ? S_W0 : S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign bus.cpu_stall = (r_level >= LVL_STALL);
  assign bus.level     = r_level;
  assign bus.drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_mips_trace_buffer.sv
// Bench for mips_trace_buffer: a negedge monitor keeps a queue of expected beats
// built from the captured events and compares every accepted beat against it.
module tb_mips_trace_buffer;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mips_trace_buffer_if #(.ADDR_W(ADDR_W)) bus ();

  mips_trace_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int          n_checks  = 0;
  int          n_fail    = 0;
  int          n_records = 0;
  int          n_beats   = 0;
  int          m_level   = 0;
  int          m_drops   = 0;
  logic [32:0] sb_q [$];
  logic        prev_hold = 1'b0;
  logic [31:0] prev_word = '0;
  logic        prev_last = 1'b0;

  // Monitor and reference model, sampled on the falling edge.
  always @(negedge clk) begin
    logic [32:0] exp_beat;
    logic        pop;
    logic        push;
    if (!reset) begin
      sb_q.delete();
      m_level   = 0;
      m_drops   = 0;
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_word !== prev_word || bus.out_last !== prev_last) begin
          n_fail++;
          $display("FAIL hold_stable: valid=%b word=%h last=%b, required valid=1 word=%h last=%b",
                   bus.out_valid, bus.out_word, bus.out_last, prev_word, prev_last);
        end
      end
      pop  = 1'b0;
      push = 1'b0;
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        n_checks++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL beat_unexpected: word=%h last=%b, required no beat", bus.out_word, bus.out_last);
        end else begin
          exp_beat = sb_q.pop_front();
          if ({bus.out_last, bus.out_word} !== exp_beat) begin
            n_fail++;
            $display("FAIL beat_value: last=%b word=%h, required last=%b word=%h",
                     bus.out_last, bus.out_word, exp_beat[32], exp_beat[31:0]);
          end
        end
        n_beats++;
        if (bus.out_last === 1'b1) begin
          n_records++;
          pop = 1'b1;
        end
      end
      if (bus.if_reg || bus.if_mem) begin
        if (m_level < DEPTH || pop) begin
          push = 1'b1;
          sb_q.push_back({1'b0, bus.if_mem, bus.if_reg, bus.pc_now[31:2]});
          sb_q.push_back({1'b0, bus.addr_now});
          sb_q.push_back({1'b1, bus.data_now});
        end else if (m_drops < 65535) begin
          m_drops++;
        end
      end
      m_level   = m_level + int'(push) - int'(pop);
      prev_hold = (bus.out_valid === 1'b1) && (bus.out_ready === 1'b0);
      prev_word = bus.out_word;
      prev_last = bus.out_last;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_event(input logic [31:0] pc, input logic [31:0] addr,
                            input logic [31:0] data, input logic r, input logic m);
    bus.pc_now   = pc;
    bus.addr_now = addr;
    bus.data_now = data;
    bus.if_reg   = r;
    bus.if_mem   = m;
    tick(1);
    bus.if_reg   = 1'b0;
    bus.if_mem   = 1'b0;
  endtask

  task automatic wait_drain(input int budget, input string tag);
    int k = 0;
    bus.out_ready = 1'b1;
    while ((sb_q.size() != 0 || bus.out_valid !== 1'b0) && k < budget) begin
      tick(1);
      k++;
    end
    n_checks++;
    if (sb_q.size() != 0 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_drain_timeout: %0d beats pending, valid=%b, required drained within %0d cycles",
               tag, sb_q.size(), bus.out_valid, budget);
    end
    n_checks++;
    if (bus.level !== 5'd0) begin
      n_fail++;
      $display("FAIL %s_level_empty: level=%0d, required 0", tag, bus.level);
    end
  endtask

  task automatic test_reset();
    reset         = 1'b0;
    bus.pc_now    = '0;
    bus.addr_now  = '0;
    bus.data_now  = '0;
    bus.if_reg    = 1'b0;
    bus.if_mem    = 1'b0;
    bus.out_ready = 1'b1;
    #10;
    n_checks++;
    if ({bus.out_valid, bus.out_last, bus.out_word, bus.cpu_stall} !== 35'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: valid=%b last=%b word=%h stall=%b, required all 0",
               bus.out_valid, bus.out_last, bus.out_word, bus.cpu_stall);
    end
    n_checks++;
    if (bus.level !== 5'd0 || bus.drop_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_counters: level=%0d drop=%0d, required 0 and 0", bus.level, bus.drop_cnt);
    end
    #8;
    reset = 1'b1;
    tick(1);
  endtask

  task automatic test_single();
    int r0 = n_records;
    int b0 = n_beats;
    send_event(32'h0000_3000, 32'd5, 32'h1234_5678, 1'b1, 1'b0);
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.level !== 5'd1) begin
      n_fail++;
      $display("FAIL single_after_push: valid=%b level=%0d, required valid=0 level=1", bus.out_valid, bus.level);
    end
    tick(1);
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_word !== 32'h4000_0C00 || bus.out_last !== 1'b0) begin
      n_fail++;
      $display("FAIL single_w0: valid=%b word=%h last=%b, required valid=1 word=40000c00 last=0",
               bus.out_valid, bus.out_word, bus.out_last);
    end
    wait_drain(50, "single");
    n_checks++;
    if (n_records - r0 != 1 || n_beats - b0 != 3) begin
      n_fail++;
      $display("FAIL single_count: records=%0d beats=%0d, required 1 and 3", n_records - r0, n_beats - b0);
    end
  endtask

  task automatic test_both_flags();
    int r0 = n_records;
    send_event(32'h0000_3004, 32'h10, 32'hFF, 1'b1, 1'b1);
    tick(1);
    n_checks++;
    if (bus.out_word !== 32'hC000_0C01) begin
      n_fail++;
      $display("FAIL both_w0: word=%h, required c0000c01", bus.out_word);
    end
    wait_drain(50, "both");
    n_checks++;
    if (n_records - r0 != 1) begin
      n_fail++;
      $display("FAIL both_count: records=%0d, required 1", n_records - r0);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] w0_first;
    w0_first = {2'b10, 30'h0000_1001};
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      send_event(32'h0000_4000 + 32'(4 * i), 32'(i), 32'hA000_0000 + 32'(i),
                 (i % 3) != 1, (i % 3) != 0);
      n_checks++;
      if (bus.level !== 5'((i > DEPTH) ? DEPTH : i) || bus.cpu_stall !== (i >= DEPTH - 2)) begin
        n_fail++;
        $display("FAIL overflow_level_%0d: level=%0d stall=%b, required level=%0d stall=%b",
                 i, bus.level, bus.cpu_stall, (i > DEPTH) ? DEPTH : i, i >= DEPTH - 2);
      end
      if (i >= 2) begin
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_word !== w0_first) begin
          n_fail++;
          $display("FAIL overflow_hold_%0d: valid=%b word=%h, required valid=1 word=%h",
                   i, bus.out_valid, bus.out_word, w0_first);
        end
      end
    end
    n_checks++;
    if (bus.drop_cnt !== 16'd4) begin
      n_fail++;
      $display("FAIL overflow_drops: drop_cnt=%0d, required 4", bus.drop_cnt);
    end
  endtask

  task automatic test_full_pop_push();
    bus.out_ready = 1'b1;
    tick(2);
    send_event(32'h0000_5000, 32'h1F, 32'hDEAD_BEEF, 1'b1, 1'b0);
    bus.out_ready = 1'b0;
    n_checks++;
    if (bus.level !== 5'd16 || bus.drop_cnt !== 16'd4) begin
      n_fail++;
      $display("FAIL fullpop_level: level=%0d drop=%0d, required level=16 drop=4", bus.level, bus.drop_cnt);
    end
    wait_drain(200, "fullpop");
  endtask

  task automatic test_random_ready();
    int r0 = n_records;
    int d0 = m_drops;
    logic [1:0] t;
    for (int i = 0; i < 40; i++) begin
      bus.out_ready = 1'($urandom_range(0, 1));
      t = 2'($urandom_range(1, 3));
      send_event(32'h0000_8000 + 32'(4 * i), $urandom, $urandom, t[0], t[1]);
      repeat ($urandom_range(2, 5)) begin
        bus.out_ready = 1'($urandom_range(0, 1));
        tick(1);
      end
    end
    wait_drain(400, "random");
    n_checks++;
    if ((n_records - r0) + (m_drops - d0) != 40) begin
      n_fail++;
      $display("FAIL random_count: records=%0d drops=%0d, required sum 40", n_records - r0, m_drops - d0);
    end
    n_checks++;
    if (bus.drop_cnt !== 16'(m_drops)) begin
      n_fail++;
      $display("FAIL random_drops: drop_cnt=%0d, required %0d", bus.drop_cnt, m_drops);
    end
  endtask

  task automatic test_reset_mid();
    int r0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      send_event(32'h0000_9000 + 32'(4 * i), 32'h100 + 32'(i), 32'h5555_0000 + 32'(i), 1'b1, 1'b0);
    bus.out_ready = 1'b1;
    tick(1);
    bus.out_ready = 1'b0;
    n_checks++;
    if (bus.out_word !== 32'h0000_0100 || bus.out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_w1: valid=%b word=%h, required valid=1 word=00000100", bus.out_valid, bus.out_word);
    end
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.out_last !== 1'b0 || bus.level !== 5'd0 || bus.drop_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL mid_async_reset: valid=%b last=%b level=%0d drop=%0d, required all 0",
               bus.out_valid, bus.out_last, bus.level, bus.drop_cnt);
    end
    tick(1);
    reset = 1'b1;
    bus.out_ready = 1'b1;
    tick(2);
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_no_ghost: valid=%b, required 0", bus.out_valid);
    end
    r0 = n_records;
    send_event(32'h0000_A000, 32'd7, 32'hCAFE_F00D, 1'b0, 1'b1);
    tick(1);
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_word !== {2'b10, 30'h0000_2800}) begin
      n_fail++;
      $display("FAIL mid_new_w0: valid=%b word=%h, required valid=1 word=%h",
               bus.out_valid, bus.out_word, {2'b10, 30'h0000_2800});
    end
    wait_drain(50, "mid");
    n_checks++;
    if (n_records - r0 != 1) begin
      n_fail++;
      $display("FAIL mid_count: records=%0d, required 1", n_records - r0);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_both_flags();
    test_overflow();
    test_full_pop_push();
    test_random_ready();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mips_trace_buffer.md
Name: mips_trace_buffer

Overview:
- Sits directly downstream of the single-cycle `mips` core and consumes its per-cycle architectural write events: PC, target, data, `if_reg`, `if_mem`.
- Packs each event into a record and buffers it in a FIFO.
- Drains each record as a 3-word valid/ready stream to the trace/log sink.
- Reports overflow and drives an almost-full stall hint back to the core.

Parameters:
- DEPTH, 16, FIFO record count; must be a power of two, ≥4.
- ADDR_W, 4, log2(DEPTH).

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- pc_now  in  32  PC of the instruction retiring this cycle.
- addr_now  in  32  register number in [4:0] for a reg write; byte address for a mem write.
- data_now  in  32  value written.
- if_reg  in  1  register-file write this cycle.
- if_mem  in  1  data-memory write this cycle.
- out_valid  out  1  out_word valid.
- out_ready  in  1  sink accepts out_word.
- out_word  out  32  serialized record word.
- out_last  out  1  marks the final word of a record.
- cpu_stall  out  1  level ≥ DEPTH-2.
- level  out  ADDR_W+1  records held, 0..DEPTH.
- drop_cnt  out  16  dropped records, saturating.

Behaviour:
- Clock and reset: one clock, `clk`. `reset` is asynchronous, active-low.
- Reset values, on reset low:
  - FIFO empty: pointers 0, level = 0.
  - FSM in IDLE.
  - out_valid, out_last, out_word, cpu_stall, drop_cnt all 0.
  - Reset mid-transfer discards all buffered and in-flight records with no further beats.
- Event capture:
  - A rising edge with (if_reg | if_mem) = 1 creates a record {type[1:0], pc_now, addr_now, data_now}.
  - type = {if_mem, if_reg}: 01 reg, 10 mem, 11 both.
  - Nothing is captured when both flags are 0.
- Push:
  - Pushed if level < DEPTH, or if level = DEPTH and a pop happens on the same edge.
  - Otherwise the record is dropped and drop_cnt += 1, saturating at 16'hFFFF.
- Pointers and level:
  - Pointers wrap modulo DEPTH.
  - level updates +1 on push only, −1 on pop only, unchanged on push+pop.
- Record serialization (head record, 3 beats):
  - W0 = {type, pc[31:2]}.
  - W1 = addr.
  - W2 = data, with out_last = 1 on W2 only.
- FSM states and transitions:
  - IDLE → W0 on the edge where level ≠ 0.
  - In W0 / W1 / W2, out_valid = 1.
  - W0 → W1 and W1 → W2 when out_valid & out_ready at the edge.
  - W2 → W0 on handshake if level after pop ≠ 0, else → IDLE.
  - The pop occurs on the W2 handshake edge.
- Output stability:
  - out_word and out_last are combinational from the head entry and the FSM state.
  - While out_valid = 1 and out_ready = 0, out_word and out_last hold constant.
  - out_valid never drops without a handshake, except on reset.
  - In IDLE: out_word = 0, out_last = 0.
- Latency and throughput:
  - A record pushed into an empty FIFO at edge N presents W0 from edge N+1.
  - With out_ready held at 1, the sustained rate is 1 record per 3 cycles.
- cpu_stall: combinational from level; advisory only. The buffer never blocks capture.

Test Plan:
1. Reset low, then high at t=18 ns; single event pc=0x00003000, if_reg=1, addr=5, data=0x12345678, out_ready=1.
   → beats 0x40000C00, 0x00000005, 0x12345678; out_last only on the third; level returns to 0; FSM IDLE.
2. if_reg=if_mem=1 with pc=0x00003004, addr=0x10, data=0xFF.
   → W0 = 0xC0000C01; only one record created.
3. out_ready=0 while 20 back-to-back events arrive, DEPTH=16.
   → level saturates at 16; drop_cnt = 4; cpu_stall high from level 14.
   → out_word held stable throughout.
4. Full FIFO, out_ready=1 on the W2 edge together with a new event.
   → new record accepted; level stays 16; drop_cnt unchanged.
5. Toggle out_ready randomly across 40 events.
   → every record emerges in order with exactly 3 beats; no beat skipped or repeated.
   → pointer wrap past index 15 verified.
6. Assert reset low mid-W1 with 5 records buffered.
   → out_valid = 0 immediately (asynchronous); level = 0; drop_cnt = 0.
   → after release, the first new event emits a full W0.
